// File: rtl/alu_ctrl_issue.sv
// RV32 ALU-control decoder feeding a 2-entry in-order issue FIFO.
// Decoded control fields are buffered, and illegal encodings are counted with saturation.
module alu_ctrl_issue #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [31:0]      instr_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [2:0]       ALUCtrl_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             Branch_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } entry_t;

  localparam logic [2:0] OP_AND = 3'd1, OP_XOR = 3'd2, OP_SLL = 3'd3, OP_ADD = 3'd4,
                         OP_SUB = 3'd5, OP_MUL = 3'd6, OP_SRA = 3'd7;

  entry_t             dec;
  entry_t [1:0]       ent_q, ent_d;
  logic   [1:0]       cnt_q, cnt_d;
  logic   [CNT_W-1:0] ill_cnt_q;
  logic               push, pop;

  // Combinational decode; register fields pass through even for illegal words.
  always_comb begin
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = instr_i[6:0];
    f3  = instr_i[14:12];
    f7  = instr_i[31:25];
    dec         = '0;
    dec.rs1     = instr_i[19:15];
    dec.rs2     = instr_i[24:20];
    dec.rd      = instr_i[11:7];
    dec.illegal = 1'b1;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b111:  dec.alu_ctrl = OP_AND;
            3'b100:  dec.alu_ctrl = OP_XOR;
            3'b001:  dec.alu_ctrl = OP_SLL;
            3'b000:  dec.alu_ctrl = OP_ADD;
            default: dec.alu_ctrl = 3'd0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_ctrl = OP_SUB;
        end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          dec.alu_ctrl = OP_MUL;
        end
        if (dec.alu_ctrl != 3'd0) begin
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      7'b0010011: begin
        if (f3 == 3'b000) dec.alu_ctrl = OP_ADD;
        else if (f3 == 3'b101 && f7 == 7'b0100000) dec.alu_ctrl = OP_SRA;
        if (dec.alu_ctrl != 3'd0) begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      7'b0000011: if (f3 == 3'b010) begin
        dec.alu_ctrl  = OP_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.illegal   = 1'b0;
      end
      7'b0100011: if (f3 == 3'b010) begin
        dec.alu_ctrl  = OP_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      7'b1100011: if (f3 == 3'b000) begin
        dec.alu_ctrl = OP_SUB;
        dec.branch   = 1'b1;
        dec.illegal  = 1'b0;
      end
      default: ;
    endcase
  end

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    cnt_d = cnt_q;
    ent_d = ent_q;
    if (flush_i) begin
      cnt_d = 2'd0;
      ent_d = '0;
    end else begin
      case (cnt_q)
        2'd0: if (push) begin
          ent_d[0] = dec;
          cnt_d    = 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            ent_d[0] = dec;
          end else if (push) begin
            ent_d[1] = dec;
            cnt_d    = 2'd2;
          end else if (pop) begin
            ent_d[0] = '0;
            cnt_d    = 2'd0;
          end
        end
        2'd2: if (pop) begin
          ent_d[0] = ent_q[1];
          ent_d[1] = '0;
          cnt_d    = 2'd1;
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= 2'd0;
      ent_q     <= '0;
      ill_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
      if (push && !flush_i && dec.illegal && ill_cnt_q != {CNT_W{1'b1}})
        ill_cnt_q <= ill_cnt_q + 1'b1;
    end
  end

  entry_t head;
  assign head          = valid_o ? ent_q[0] : '0;
  assign ALUCtrl_o     = head.alu_ctrl;
  assign ALUSrc_o      = head.alu_src;
  assign RegWrite_o    = head.reg_write;
  assign MemRead_o     = head.mem_read;
  assign MemWrite_o    = head.mem_write;
  assign Branch_o      = head.branch;
  assign rs1_o         = head.rs1;
  assign rs2_o         = head.rs2;
  assign rd_o          = head.rd;
  assign illegal_o     = head.illegal;
  assign illegal_cnt_o = ill_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue; a second instance with CNT_W=2 checks counter saturation.
module tb_alu_ctrl_issue;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, flush_i, ready_i;
  logic [31:0] instr_i;

  logic       ready_o, valid_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, illegal_o;
  logic [2:0] ALUCtrl_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [7:0] illegal_cnt_o;

  logic       ready_s, valid_s, src_s, rw_s, mr_s, mw_s, br_s, ill_s;
  logic [2:0] alu_s;
  logic [4:0] rs1_s, rs2_s, rd_s;
  logic [1:0] cnt_s;

  int n_chk = 0, n_fail = 0, exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  alu_ctrl_issue #(.CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i), .ready_o(ready_o),
    .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o), .ALUCtrl_o(ALUCtrl_o),
    .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .Branch_o(Branch_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o));

  alu_ctrl_issue #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i), .ready_o(ready_s),
    .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_s), .ALUCtrl_o(alu_s),
    .ALUSrc_o(src_s), .RegWrite_o(rw_s), .MemRead_o(mr_s),
    .MemWrite_o(mw_s), .Branch_o(br_s), .rs1_o(rs1_s), .rs2_o(rs2_s),
    .rd_o(rd_s), .illegal_o(ill_s), .illegal_cnt_o(cnt_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {valid, alu[2:0], src, rw, mr, mw, br, illegal}
  function automatic logic [31:0] ctl(input logic v, input logic [2:0] alu, input logic src,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic br, input logic ill);
    return {22'd0, v, alu, src, rw, mr, mw, br, ill};
  endfunction

  function automatic logic [31:0] head_ctl();
    return {22'd0, valid_o, ALUCtrl_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, illegal_o};
  endfunction

  function automatic logic [31:0] head_regs();
    return {17'd0, rs1_o, rs2_o, rd_o};
  endfunction

  function automatic logic [31:0] regs(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {17'd0, a, b, d};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push one word into an empty FIFO, check the head, then pop it.
  task automatic dec_case(input string tag, input logic [31:0] ins, input logic [2:0] alu,
                          input logic src, input logic rw, input logic mr, input logic mw,
                          input logic br, input logic ill, input logic [31:0] exp_regs);
    valid_i = 1'b1; instr_i = ins; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    if (ill) exp_cnt++;
    chk({tag, "_ctl"}, head_ctl(), ctl(1'b1, alu, src, rw, mr, mw, br, ill));
    chk({tag, "_regs"}, head_regs(), exp_regs);
    tick();
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0; instr_i = '0;
    #12;
    chk("rst_ctl", head_ctl(), ctl(1'b0, 3'd0, 0, 0, 0, 0, 0, 0));
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_cnt", {24'd0, illegal_cnt_o}, 32'd0);
    rst_i = 1'b1;
    tick();

    // sub x0,x0,x0: one-cycle latency from empty
    valid_i = 1'b1; instr_i = 32'h40000033; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("sub_ctl", head_ctl(), ctl(1'b1, 3'd5, 0, 1, 0, 0, 0, 0));
    tick();
    chk("empty_ctl", head_ctl(), ctl(1'b0, 3'd0, 0, 0, 0, 0, 0, 0));
    chk("empty_regs", head_regs(), 32'd0);

    dec_case("and",   32'h0020F0B3, 3'd1, 0, 1, 0, 0, 0, 0, regs(5'd1, 5'd2, 5'd1));
    dec_case("xor",   32'h0020C0B3, 3'd2, 0, 1, 0, 0, 0, 0, regs(5'd1, 5'd2, 5'd1));
    dec_case("sll",   32'h002090B3, 3'd3, 0, 1, 0, 0, 0, 0, regs(5'd1, 5'd2, 5'd1));
    dec_case("add",   32'h002080B3, 3'd4, 0, 1, 0, 0, 0, 0, regs(5'd1, 5'd2, 5'd1));
    dec_case("mul",   32'h02208033, 3'd6, 0, 1, 0, 0, 0, 0, regs(5'd1, 5'd2, 5'd0));
    dec_case("addi",  32'h00108093, 3'd4, 1, 1, 0, 0, 0, 0, regs(5'd1, 5'd1, 5'd1));
    dec_case("sw",    32'h0020A023, 3'd4, 1, 0, 0, 1, 0, 0, regs(5'd1, 5'd2, 5'd0));
    dec_case("beq",   32'h00208063, 3'd5, 0, 0, 0, 0, 1, 0, regs(5'd1, 5'd2, 5'd0));
    dec_case("bad_r", 32'h402090B3, 3'd0, 0, 0, 0, 0, 0, 1, regs(5'd1, 5'd2, 5'd1));
    dec_case("srli",  32'h0020D093, 3'd0, 0, 0, 0, 0, 0, 1, regs(5'd1, 5'd2, 5'd1));
    chk("cnt_after_table", {24'd0, illegal_cnt_o}, exp_cnt);

    // srai then lw with stalled downstream; full FIFO refuses a third word
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h4020D093;
    tick();
    instr_i = 32'h0020A183;
    tick();
    chk("full_ready", {31'd0, ready_o}, 32'd0);
    chk("full_head", head_ctl(), ctl(1'b1, 3'd7, 1, 1, 0, 0, 0, 0));
    instr_i = 32'hFFFFFFFF;
    tick();
    valid_i = 1'b0;
    chk("full_hold", head_ctl(), ctl(1'b1, 3'd7, 1, 1, 0, 0, 0, 0));
    chk("full_no_cnt", {24'd0, illegal_cnt_o}, exp_cnt);
    ready_i = 1'b1;
    tick();
    chk("lw_ctl", head_ctl(), ctl(1'b1, 3'd4, 1, 1, 1, 0, 0, 0));
    chk("lw_regs", head_regs(), regs(5'd1, 5'd2, 5'd3));
    chk("lw_ready", {31'd0, ready_o}, 32'd1);
    tick();
    chk("drain_valid", {31'd0, valid_o}, 32'd0);

    // fresh reset, then illegal counting and saturation
    rst_i = 1'b0; #1; rst_i = 1'b1; exp_cnt = 0;
    tick();
    valid_i = 1'b1; instr_i = 32'hFFFFFFFF; ready_i = 1'b1;
    tick();
    tick();
    chk("sat_cnt2", {30'd0, cnt_s}, 32'd2);
    tick();
    valid_i = 1'b0;
    chk("ill_ctl", head_ctl(), ctl(1'b1, 3'd0, 0, 0, 0, 0, 0, 1));
    chk("ill_cnt3", {24'd0, illegal_cnt_o}, 32'd3);
    chk("sat_cnt3", {30'd0, cnt_s}, 32'd3);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("ill_cnt4", {24'd0, illegal_cnt_o}, 32'd4);
    chk("sat_hold", {30'd0, cnt_s}, 32'd3);
    tick();

    // flush at count 2 with an illegal word offered
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h002080B3;
    tick();
    tick();
    chk("pre_flush_ready", {31'd0, ready_o}, 32'd0);
    instr_i = 32'hFFFFFFFF; flush_i = 1'b1; ready_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    chk("flush_ctl", head_ctl(), ctl(1'b0, 3'd0, 0, 0, 0, 0, 0, 0));
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    chk("flush_cnt", {24'd0, illegal_cnt_o}, 32'd4);

    // simultaneous push/pop at count 1
    valid_i = 1'b1; instr_i = 32'h002080B3;
    tick();
    instr_i = 32'h02208033; ready_i = 1'b1;
    tick();
    valid_i = 1'b0; ready_i = 1'b0;
    chk("pp_head", head_ctl(), ctl(1'b1, 3'd6, 0, 1, 0, 0, 0, 0));
    chk("pp_ready", {31'd0, ready_o}, 32'd1);
    ready_i = 1'b1;
    tick();
    chk("pp_single", {31'd0, valid_o}, 32'd0);

    // asynchronous reset between edges with two entries buffered
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'hFFFFFFFF;
    tick();
    tick();
    valid_i = 1'b0;
    chk("pre_rst_cnt", {24'd0, illegal_cnt_o}, 32'd6);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_ctl", head_ctl(), ctl(1'b0, 3'd0, 0, 0, 0, 0, 0, 0));
    chk("arst_cnt", {24'd0, illegal_cnt_o}, 32'd0);
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    #1 rst_i = 1'b1;
    valid_i = 1'b1; instr_i = 32'h40000033; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("post_rst_head", head_ctl(), ctl(1'b1, 3'd5, 0, 1, 0, 0, 0, 0));
    tick();
    chk("post_rst_empty", {31'd0, valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
